// File: rtl/mbist_pkg.sv
// March C- element definitions shared by the sequencer and its bench.
// Element tables: direction, pair/single, read and write backgrounds.
package mbist_pkg;

    typedef enum logic [2:0] {
        M0,
        M1,
        M2,
        M3,
        M4,
        M5,
        DONE
    } march_elem_t;

    localparam int MAX_DATA_W = 64;
    localparam logic [MAX_DATA_W-1:0] ALL0 = '0;
    localparam logic [MAX_DATA_W-1:0] ALL1 = '1;

    function automatic logic elem_down(march_elem_t e);
        case (e)
            M3, M4, M5: return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic elem_pair(march_elem_t e);
        case (e)
            M1, M2, M3, M4: return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction

    function automatic logic elem_rd_val(march_elem_t e);
        case (e)
            M2, M4:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic elem_wr_val(march_elem_t e);
        case (e)
            M1, M3:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic march_elem_t elem_next(march_elem_t e);
        case (e)
            M0:      return M1;
            M1:      return M2;
            M2:      return M3;
            M3:      return M4;
            M4:      return M5;
            default: return DONE;
        endcase
    endfunction

endpackage

// File: rtl/mbist_march_sequencer_if.sv
// Command/memory bundle between controller, sequencer and memory/comparator.
// The sequencer is the master: it consumes ld/NbarT and drives the rest.
interface mbist_march_sequencer_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              ld;
    logic              NbarT;
    logic              cout;
    logic [ADDR_W-1:0] addr;
    logic              rwbar;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] expected;
    logic              cmp_en;

    modport master (
        input  ld, NbarT,
        output cout, addr, rwbar, wdata, expected, cmp_en
    );

    modport slave (
        output ld, NbarT,
        input  cout, addr, rwbar, wdata, expected, cmp_en
    );
endinterface

// File: rtl/mbist_addr_counter.sv
// Up/down address counter with load-zero, load-max and last-address flag.
// Priority: clr over load_max over en.
module mbist_addr_counter #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load_max,
    input  logic              en,
    input  logic              down,
    output logic [ADDR_W-1:0] count,
    output logic              last
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load_max) begin
            count <= '1;
        end else if (en) begin
            count <= down ? count - 1'b1 : count + 1'b1;
        end
    end

    assign last = down ? (count == '0) : (count == '1);
endmodule

// File: rtl/mbist_march_sequencer.sv
// March C- sequencer: walks M0..M5 over the memory, then parks in DONE.
// All memory-side outputs decode combinationally from element/phase/addr.
module mbist_march_sequencer
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    mbist_march_sequencer_if.master bus
);
    march_elem_t       elem, elem_n;
    logic              phase, phase_n;
    logic              clr, load_max, cnt_en, last;
    logic [ADDR_W-1:0] addr;
    logic              is_read, active;
    logic [DATA_W-1:0] rd_word, wr_word;

    mbist_addr_counter #(.ADDR_W(ADDR_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .load_max (load_max),
        .en       (cnt_en),
        .down     (elem_down(elem)),
        .count    (addr),
        .last     (last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            elem  <= M0;
            phase <= 1'b0;
        end else begin
            elem  <= elem_n;
            phase <= phase_n;
        end
    end

    always_comb begin
        elem_n   = elem;
        phase_n  = phase;
        clr      = 1'b0;
        load_max = 1'b0;
        cnt_en   = 1'b0;
        if (bus.ld) begin
            elem_n  = M0;
            phase_n = 1'b0;
            clr     = 1'b1;
        end else if (bus.NbarT && elem != DONE) begin
            if (elem_pair(elem) && !phase) begin
                phase_n = 1'b1;
            end else begin
                phase_n = 1'b0;
                if (last) begin
                    // Each element starts at its own end of the array.
                    elem_n = elem_next(elem);
                    if (elem_n != DONE && elem_down(elem_n))
                        load_max = 1'b1;
                    else
                        clr = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
        end
    end

    always_comb begin
        active  = (elem != DONE);
        is_read = elem_pair(elem) ? !phase : !(elem == M0);
        rd_word = elem_rd_val(elem) ? ALL1[DATA_W-1:0] : ALL0[DATA_W-1:0];
        wr_word = elem_wr_val(elem) ? ALL1[DATA_W-1:0] : ALL0[DATA_W-1:0];
        bus.addr     = addr;
        bus.rwbar    = is_read;
        bus.wdata    = is_read ? '0 : wr_word;
        bus.expected = (is_read && active) ? rd_word : '0;
        bus.cmp_en   = is_read && active && bus.NbarT;
        bus.cout     = !active || (elem == M5 && addr == '0);
    end
endmodule

// File: tb/tb_mbist_march_sequencer.sv
// Directed bench for the March C- sequencer at ADDR_W=2 (40 operations).
// Expected op list is written out element by element from the algorithm.
module tb_mbist_march_sequencer;
    localparam int AW = 2;
    localparam int DW = 8;

    typedef struct {
        logic [AW-1:0] a;
        logic          rd;
        logic          v;
    } op_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    op_t  ops[$];

    mbist_march_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mbist_march_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return {11'b0, bus.addr, bus.rwbar, bus.wdata, bus.expected,
                bus.cmp_en, bus.cout};
    endfunction

    function automatic logic [31:0] vec(logic [AW-1:0] a, logic rd,
                                        logic v, logic nb, logic co);
        logic [DW-1:0] w;
        w = {DW{v}};
        return {11'b0, a, rd, rd ? 8'h00 : w, rd ? w : 8'h00,
                rd & nb, co};
    endfunction

    task automatic push(input int a, input logic rd, input logic v);
        op_t o;
        o.a  = AW'(a);
        o.rd = rd;
        o.v  = v;
        ops.push_back(o);
    endtask

    task automatic adv(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reload();
        bus.ld = 1'b1;
        adv(1);
        bus.ld = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 4; a++) push(a, 0, 0);
        for (int a = 0; a < 4; a++) begin push(a, 1, 0); push(a, 0, 1); end
        for (int a = 0; a < 4; a++) begin push(a, 1, 1); push(a, 0, 0); end
        for (int a = 3; a >= 0; a--) begin push(a, 1, 0); push(a, 0, 1); end
        for (int a = 3; a >= 0; a--) begin push(a, 1, 1); push(a, 0, 0); end
        for (int a = 3; a >= 0; a--) push(a, 1, 0);

        bus.ld    = 1'b0;
        bus.NbarT = 1'b0;
        adv(1);
        chk("reset", obs(), vec(0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b1;
        adv(1);
        chk("release", obs(), vec(0, 0, 0, 0, 0));

        reload();
        bus.NbarT = 1'b1;
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("op%0d", i), obs(),
                vec(ops[i].a, ops[i].rd, ops[i].v, 1'b1, i == 39));
            adv(1);
        end
        for (int i = 0; i < 5; i++) begin
            chk("done", obs(), {11'b0, 2'd0, 1'b1, 16'h0000, 1'b0, 1'b1});
            adv(1);
        end
        reload();
        chk("done_ld", obs(), vec(0, 0, 0, 1'b1, 0));

        reload();
        adv(9);
        chk("pre_freeze", obs(), vec(2, 0, 1, 1'b1, 0));
        bus.NbarT = 1'b0;
        for (int i = 0; i < 3; i++) begin
            adv(1);
            chk("freeze", obs(), vec(2, 0, 1, 1'b0, 0));
        end
        bus.NbarT = 1'b1;
        adv(1);
        chk("resume", obs(), vec(3, 1, 0, 1'b1, 0));

        reload();
        adv(32);
        chk("m4_a1", obs(), vec(1, 1, 1, 1'b1, 0));
        bus.ld = 1'b1;
        adv(1);
        bus.ld = 1'b0;
        chk("restart", obs(), vec(0, 0, 0, 1'b1, 0));
        adv(1);
        chk("restart_nx", obs(), vec(1, 0, 0, 1'b1, 0));

        reload();
        adv(20);
        chk("m3_a3", obs(), vec(3, 1, 0, 1'b1, 0));
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst", obs(), vec(0, 0, 0, 1'b1, 0));
        @(negedge clk);
        rst = 1'b1;
        adv(1);
        chk("post_rst", obs(), vec(1, 0, 0, 1'b1, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mbist_march_sequencer.md
Name: mbist_march_sequencer

Overview:
- Counterpart of the MBIST controller: consumes its `ld`/`NbarT` commands and returns `cout` when the test pattern is exhausted.
- Walks a March C- algorithm over the memory under test, generating address, read/write strobe, write data and expected read data.
- Feeds the memory and the comparator; it replaces a plain address counter in the BIST datapath.

Parameters:
- ADDR_W, 6, address width; memory depth N = 2**ADDR_W words.
- DATA_W, 8, data word width; background patterns are all-0 / all-1 of this width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- ld  input  1  load command from the controller: reinitialise the sequence.
- NbarT  input  1  test-mode enable from the controller: 1 = advance one operation per cycle.
- cout  output  1  terminal indication to the controller: final operation presented, or sequence done.
- addr  output  ADDR_W  memory address of the current operation.
- rwbar  output  1  1 = read, 0 = write.
- wdata  output  DATA_W  write data; valid when rwbar=0.
- expected  output  DATA_W  expected read data; valid when rwbar=1.
- cmp_en  output  1  1 when the current operation is a read during test (rwbar=1 and NbarT=1); the comparator samples only then.

Behaviour:
- State is registered: element (enum M0..M5, DONE), addr, phase (0 = first op, 1 = second op of a read-write pair).
- Reset (rst=0, async) and the load value (ld=1 at a clock edge) are identical: element=M0, addr=0, phase=0.
  - Resulting outputs: rwbar=0, wdata=0, expected=0, cmp_en=0, cout=0.
- Priority at each edge:
  - ld=1 always loads, regardless of NbarT.
  - Otherwise NbarT=1 advances one operation.
  - Otherwise all state holds. Dropping NbarT mid-test freezes the sequence; reasserting resumes from the same operation.
- March elements; every output is combinational from state:
  - M0, up: w0, one op per address.
  - M1, up: r0 then w1.
  - M2, up: r1 then w0.
  - M3, down: r0 then w1.
  - M4, down: r1 then w0.
  - M5, down: r0, one op per address.
- Data values: "0" means all-zeros and "1" means all-ones at DATA_W. wdata and expected are both 0 whenever not defined by the current op.
- Two-op elements: phase 0 is the read and phase 1 the write. Advancing in phase 0 sets phase=1 at the same address. Advancing in phase 1 clears phase and steps the address.
- Addressing order:
  - Up elements run 0 → N-1. Down elements run N-1 → 0.
  - On the last address of an element (N-1 for up, 0 for down), the next advance moves to the next element.
  - Entering M3 loads addr=N-1. Entering M1 or M2 loads addr=0.
  - M2 → M3 switches direction, so addr goes from N-1 to N-1.
- Totals: 10·N operations; with ADDR_W=6, 640 cycles of NbarT=1.
- cout is high when either:
  - element=M5 and addr=0 (the final read), or
  - element=DONE.
- The controller samples cout during the final read. At that same edge the sequencer advances to DONE.
- In DONE, NbarT has no effect: addr=0, rwbar=1, cmp_en=0, wdata=0, expected=0, cout=1. Only ld or rst leaves DONE.
- Address arithmetic is unsigned ADDR_W-bit. No wrap occurs inside an element; transitions happen only at the element boundaries above.
- ld while in any element mid-test restarts at M0 with no partial completion.

Decomposition:
- Package mbist_pkg holds:
  - enum march_elem_t {M0..M5, DONE};
  - the per-element constant tables: direction, op count (1/2), read value, write value;
  - the constants ALL0 / ALL1 functions of DATA_W.
- Sub-module mbist_addr_counter: an ADDR_W up/down counter with load-zero, load-max, enable and direction inputs, plus a last-address flag. The sequencer FSM instantiates it once.

Test Plan:
- Reset then release: rst=0 for 1 cycle, then 1 → addr=0, rwbar=0, wdata=0, cout=0, cmp_en=0.
- Full run, ADDR_W=2, ld=1 for one cycle, then NbarT=1:
  - op sequence: addr 0,1,2,3 writing 0; then (r0,w1) at 0..3; then (r1,w0) at 0..3; then (r0,w1) at 3..0; then (r1,w0) at 3..0; then r0 at 3..0;
  - cout=1 first on op 40 (M5, addr 0) and stays 1 in DONE.
- Freeze: during M1 at addr=2 phase=1, NbarT=0 for 3 cycles → addr=2, rwbar=0, wdata=all-ones held, cmp_en=0. Resume → next op is r0 at addr=3.
- Restart: ld=1 and NbarT=1 together during M4 addr=1 → next cycle element M0, addr=0, cout=0.
- Async reset mid-test: rst=0 between edges in M3 → outputs reach load values immediately, without a clock edge.
- DONE hold: NbarT kept 1 for 5 cycles after completion → cout=1, cmp_en=0, addr=0 constant. Then ld=1 → cout=0.
